// File: rtl/sync_pkg.sv
// sync_pkg: shared constants and elaboration helpers for the multi-channel synchroniser
package sync_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int cnt_width(input int filter_len);
    return clog2(filter_len) < 1 ? 1 : clog2(filter_len);
  endfunction
  function automatic bit params_ok(input int stages, input int filter_len);
    return stages >= SYNC_STAGES_MIN && stages <= SYNC_STAGES_MAX && filter_len >= 1;
  endfunction
endpackage

// File: rtl/sync_filter_ch.sv
// sync_filter_ch: one channel of flop-chain synchroniser, stability filter and edge pulses
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter int   FILTER_LEN  = 1,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_in,
  input  logic rst_i,
  input  logic serial_in,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_nxt,
  output logic fall_nxt
);
  localparam int CW = cnt_width(FILTER_LEN);
  logic [STAGES-1:0] chain;
  logic [CW-1:0]     cnt;
  logic              s, upd;
  assign s        = chain[STAGES-1];
  // a differing sample that completes the run is accepted on this edge
  assign upd      = (s != level_o) && (cnt == CW'(FILTER_LEN - 1));
  assign rise_nxt = upd & s;
  assign fall_nxt = upd & ~s;
  always_ff @(posedge clk_in or posedge rst_i) begin
    if (rst_i) begin
      chain   <= {STAGES{RESET_VALUE}};
      cnt     <= '0;
      level_o <= RESET_VALUE;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      chain   <= {chain[STAGES-2:0], serial_in};
      cnt     <= (s == level_o || upd) ? '0 : cnt + CW'(1);
      level_o <= upd ? s : level_o;
      rise_o  <= rise_nxt;
      fall_o  <= fall_nxt;
    end
  end
endmodule

// File: rtl/sync_filter.sv
// sync_filter: WIDTH independent synchronised, glitch-filtered channels with rise/fall/change pulses
module sync_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILTER_LEN  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk_in,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] serial_in,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);
  if (!params_ok(STAGES, FILTER_LEN)) begin : g_bad_params
    $error("sync_filter: STAGES must be %0d..%0d and FILTER_LEN >= 1", SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end
  logic [WIDTH-1:0] rise_nxt, fall_nxt;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VALUE(RESET_VALUE[i])
    ) u_ch (
      .clk_in   (clk_in),
      .rst_i    (rst_i),
      .serial_in(serial_in[i]),
      .level_o  (level_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .rise_nxt (rise_nxt[i]),
      .fall_nxt (fall_nxt[i])
    );
  end
  // built from next-state pulses so change_o lines up with rise_o/fall_o
  always_ff @(posedge clk_in or posedge rst_i) begin
    if (rst_i) change_o <= 1'b0;
    else change_o <= |(rise_nxt | fall_nxt);
  end
endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed bench for sync_filter with a delay-line/run-length reference model
module tb_sync_filter;
  logic       clk_in = 1'b0;
  logic       rst_i  = 1'b0;
  logic [3:0] sa = 4'b1010, sb = 4'b0000;
  logic [3:0] la, ra, fa, lb, rb, fb;
  logic       ca, cb;
  int         checks = 0, failures = 0;
  bit         armed = 1'b0;
  int         stg [2] = '{2, 3};
  int         flen[2] = '{3, 1};
  logic [3:0] rv  [2] = '{4'b0101, 4'b0000};
  logic [3:0] m_dl[2][4];
  logic [3:0] m_lvl[2], m_rise[2], m_fall[2];
  logic       m_chg[2];
  int         m_run[2][4];

  always #5 clk_in = ~clk_in;

  sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_LEN(3), .RESET_VALUE(4'b0101)) u_a (
    .clk_in(clk_in), .rst_i(rst_i), .serial_in(sa),
    .level_o(la), .rise_o(ra), .fall_o(fa), .change_o(ca));
  sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_LEN(1), .RESET_VALUE(4'b0000)) u_b (
    .clk_in(clk_in), .rst_i(rst_i), .serial_in(sb),
    .level_o(lb), .rise_o(rb), .fall_o(fb), .change_o(cb));

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // reference: s is the input seen STAGES edges ago; a level is accepted after FILTER_LEN straight differing samples
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lvl[d] = rv[d]; m_rise[d] = '0; m_fall[d] = '0; m_chg[d] = 1'b0;
      for (int k = 0; k < 4; k++) begin m_dl[d][k] = rv[d]; m_run[d][k] = 0; end
    end
  endtask

  task automatic model_edge();
    logic [3:0] sp, nr, nf;
    for (int d = 0; d < 2; d++) begin
      sp = m_dl[d][stg[d]-1];
      for (int k = 3; k > 0; k--) m_dl[d][k] = m_dl[d][k-1];
      m_dl[d][0] = (d == 0) ? sa : sb;
      nr = '0; nf = '0;
      for (int c = 0; c < 4; c++) begin
        if (sp[c] !== m_lvl[d][c]) begin
          m_run[d][c]++;
          if (m_run[d][c] == flen[d]) begin
            m_lvl[d][c] = sp[c]; nr[c] = sp[c]; nf[c] = ~sp[c]; m_run[d][c] = 0;
          end
        end else m_run[d][c] = 0;
      end
      m_rise[d] = nr; m_fall[d] = nf; m_chg[d] = |(nr | nf);
    end
  endtask

  always @(posedge clk_in or posedge rst_i) begin
    if (rst_i) model_reset();
    else model_edge();
  end

  always @(negedge clk_in) begin
    if (armed) begin
      chk("model_a_level", la, m_lvl[0]);
      chk("model_a_rise", ra, m_rise[0]);
      chk("model_a_fall", fa, m_fall[0]);
      chk("model_a_change", {3'b0, ca}, {3'b0, m_chg[0]});
      chk("model_b_level", lb, m_lvl[1]);
      chk("model_b_rise", rb, m_rise[1]);
      chk("model_b_fall", fb, m_fall[1]);
      chk("model_b_change", {3'b0, cb}, {3'b0, m_chg[1]});
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic exp_a(input string name, input logic [3:0] l, r, f, input logic c);
    chk({name, "_level"}, la, l);
    chk({name, "_rise"}, ra, r);
    chk({name, "_fall"}, fa, f);
    chk({name, "_change"}, {3'b0, ca}, {3'b0, c});
  endtask

  initial begin
    #1 rst_i = 1'b1;
    armed = 1'b1;
    #1 exp_a("reset", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    chk("reset_b_level", lb, 4'b0000);
    repeat (2) tick();
    rst_i = 1'b0;
    // reset release with serial_in already differing from RESET_VALUE
    for (int k = 1; k <= 4; k++) begin tick(); exp_a("rel_hold", 4'b0101, 4'b0000, 4'b0000, 1'b0); end
    tick(); exp_a("rel_edge5", 4'b1010, 4'b1010, 4'b0101, 1'b1);
    tick(); exp_a("rel_after", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    // clean step on channel 0
    sa = 4'b1011;
    for (int k = 1; k <= 4; k++) begin tick(); exp_a("step_hold", 4'b1010, 4'b0000, 4'b0000, 1'b0); end
    tick(); exp_a("step_edge5", 4'b1011, 4'b0001, 4'b0000, 1'b1);
    tick(); exp_a("step_after", 4'b1011, 4'b0000, 4'b0000, 1'b0);
    // 2-cycle glitch on channel 2 is rejected
    sa = 4'b1111;
    repeat (2) tick();
    sa = 4'b1011;
    for (int k = 1; k <= 10; k++) begin tick(); exp_a("glitch2", 4'b1011, 4'b0000, 4'b0000, 1'b0); end
    // 3-cycle excursion is accepted, and so is the return
    sa = 4'b1111;
    repeat (3) tick();
    sa = 4'b1011;
    tick(); exp_a("pulse3_e4", 4'b1011, 4'b0000, 4'b0000, 1'b0);
    tick(); exp_a("pulse3_e5", 4'b1111, 4'b0100, 4'b0000, 1'b1);
    tick(); exp_a("pulse3_e6", 4'b1111, 4'b0000, 4'b0000, 1'b0);
    tick(); exp_a("pulse3_e7", 4'b1111, 4'b0000, 4'b0000, 1'b0);
    tick(); exp_a("pulse3_e8", 4'b1011, 4'b0000, 4'b0100, 1'b1);
    tick(); exp_a("pulse3_e9", 4'b1011, 4'b0000, 4'b0000, 1'b0);
    // async reset in the middle of a count
    sa = 4'b1010;
    for (int k = 1; k <= 3; k++) begin tick(); exp_a("midrst_pre", 4'b1011, 4'b0000, 4'b0000, 1'b0); end
    #2 rst_i = 1'b1;
    #1 exp_a("midrst_async", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    tick(); exp_a("midrst_held", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    rst_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin tick(); exp_a("midrst_hold", 4'b0101, 4'b0000, 4'b0000, 1'b0); end
    tick(); exp_a("midrst_e5", 4'b1010, 4'b1010, 4'b0101, 1'b1);
    tick(); exp_a("midrst_after", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    // channels 1 and 3 fall together
    sa = 4'b0000;
    for (int k = 1; k <= 4; k++) begin tick(); exp_a("simul_hold", 4'b1010, 4'b0000, 4'b0000, 1'b0); end
    tick(); exp_a("simul_e5", 4'b0000, 4'b0000, 4'b1010, 1'b1);
    tick(); exp_a("simul_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // unfiltered instance: toggle channel 0 every cycle
    sb = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("nofilt_level", lb, {3'b0, k >= 4 && k % 2 == 0});
      chk("nofilt_rise", rb, {3'b0, k >= 4 && k % 2 == 0});
      chk("nofilt_fall", fb, {3'b0, k >= 5 && k % 2 == 1});
      chk("nofilt_change", {3'b0, cb}, {3'b0, k >= 4});
      sb[0] = ~sb[0];
    end
    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
